// File: rtl/axi_uart_rx_framer_pkg.sv
// Shared UART constants: parity-mode encoding used by the receive framer,
// the transmit side and the register map, plus the parity-error helper.
// No ports; imported by axi_uart_rx_framer.
package axi_uart_rx_framer_pkg;

   // parity_enable: 1 = the ninth bit carries parity and is checked
   localparam logic PAR_ENABLED = 1'b1;
   // parity_odd: 1 = odd parity (data + parity has an odd number of ones)
   localparam logic PAR_ODD     = 1'b1;

   localparam int unsigned ERR_CNT_W = 16;

   // A 9-bit word {parity, data} is in error when its total ones count does
   // not match the selected mode. Always clean when parity is disabled.
   function automatic logic parity_error(input logic [8:0] word,
                                         input logic       enable,
                                         input logic       odd);
      return (enable == PAR_ENABLED) & ((^word) ^ (odd == PAR_ODD));
   endfunction

endpackage

// File: rtl/axi_uart_rx_framer.sv
// UART RX framer: checks/strips parity on the 9-bit receive stream and emits
// an 8-bit AXI-stream with per-byte parity error in tuser and tlast framing on
// idle timeout or maximum packet length.
// Ports: clk/rst (sync, active-high); i_t* 9-bit input stream; o_t* 8-bit
// output stream; parity_enable/parity_odd mode; timeout/max_len framing
// limits (0 = disabled); err_count saturating error counter with clear_count.
module axi_uart_rx_framer
   import axi_uart_rx_framer_pkg::*;
#(
   parameter int MAXW = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [8:0]           i_tdata,
   input  logic                 i_tvalid,
   output logic                 i_tready,
   output logic [7:0]           o_tdata,
   output logic                 o_tuser,
   output logic                 o_tlast,
   output logic                 o_tvalid,
   input  logic                 o_tready,
   input  logic                 parity_enable,
   input  logic                 parity_odd,
   input  logic [MAXW-1:0]      timeout,
   input  logic [MAXW-1:0]      max_len,
   output logic [ERR_CNT_W-1:0] err_count,
   input  logic                 clear_count
);

   localparam logic [MAXW-1:0] LEN_ONE = {{(MAXW-1){1'b0}}, 1'b1};

   // hold stage: newest byte, kept until we know whether it ends the packet
   logic                 h_valid_q, h_valid_d;
   logic [7:0]           h_data_q, h_data_d;
   logic                 h_err_q, h_err_d;

   logic [MAXW-1:0]      idle_q, idle_d;
   logic [MAXW-1:0]      pkt_len_q, pkt_len_d;

   logic [7:0]           o_tdata_q, o_tdata_d;
   logic                 o_tuser_q, o_tuser_d;
   logic                 o_tlast_q, o_tlast_d;
   logic                 o_tvalid_q, o_tvalid_d;

   logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

   logic in_err;
   logic out_free;
   logic expired;
   logic at_max;
   logic rel;
   logic rel_last;
   logic in_rdy;
   logic accept;

   always_comb begin
      in_err   = parity_error(i_tdata, parity_enable, parity_odd);
      out_free = ~o_tvalid_q | o_tready;
      expired  = (timeout != '0) && (idle_q >= timeout);
      // >= rather than == so a max_len shrunk mid-packet closes it on the next release
      at_max   = (max_len != '0) && (pkt_len_q >= (max_len - LEN_ONE));
      rel      = h_valid_q & out_free & (i_tvalid | expired | at_max);
      // a byte arriving on the expiry cycle keeps the packet open
      rel_last = at_max | (expired & ~i_tvalid);
      in_rdy   = ~h_valid_q | rel;
      accept   = i_tvalid & in_rdy;
   end

   always_comb begin
      h_valid_d   = h_valid_q;
      h_data_d    = h_data_q;
      h_err_d     = h_err_q;
      idle_d      = idle_q;
      pkt_len_d   = pkt_len_q;
      o_tdata_d   = o_tdata_q;
      o_tuser_d   = o_tuser_q;
      o_tlast_d   = o_tlast_q;
      o_tvalid_d  = o_tvalid_q;
      err_count_d = err_count_q;

      if (accept) begin
         h_valid_d = 1'b1;
         h_data_d  = i_tdata[7:0];
         h_err_d   = in_err;
      end else if (rel) begin
         h_valid_d = 1'b0;
      end

      // idle keeps counting under back-pressure so a stalled byte still times out
      if (accept) begin
         idle_d = '0;
      end else if (h_valid_q && !i_tvalid && (idle_q != '1)) begin
         idle_d = idle_q + LEN_ONE;
      end

      if (rel) begin
         pkt_len_d  = rel_last ? '0 : (pkt_len_q + LEN_ONE);
         o_tdata_d  = h_data_q;
         o_tuser_d  = h_err_q;
         o_tlast_d  = rel_last;
         o_tvalid_d = 1'b1;
      end else if (o_tready) begin
         o_tvalid_d = 1'b0;
      end

      if (clear_count) begin
         err_count_d = '0;
      end else if (accept && in_err && (err_count_q != '1)) begin
         err_count_d = err_count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         h_valid_q   <= 1'b0;
         h_data_q    <= '0;
         h_err_q     <= 1'b0;
         idle_q      <= '0;
         pkt_len_q   <= '0;
         o_tdata_q   <= '0;
         o_tuser_q   <= 1'b0;
         o_tlast_q   <= 1'b0;
         o_tvalid_q  <= 1'b0;
         err_count_q <= '0;
      end else begin
         h_valid_q   <= h_valid_d;
         h_data_q    <= h_data_d;
         h_err_q     <= h_err_d;
         idle_q      <= idle_d;
         pkt_len_q   <= pkt_len_d;
         o_tdata_q   <= o_tdata_d;
         o_tuser_q   <= o_tuser_d;
         o_tlast_q   <= o_tlast_d;
         o_tvalid_q  <= o_tvalid_d;
         err_count_q <= err_count_d;
      end
   end

   assign i_tready  = in_rdy;
   assign o_tdata   = o_tdata_q;
   assign o_tuser   = o_tuser_q;
   assign o_tlast   = o_tlast_q;
   assign o_tvalid  = o_tvalid_q;
   assign err_count = err_count_q;

endmodule
